// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader: FSM state encoding,
// header size and the byte order used to assemble 16-bit program words.
package program_loader_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_LEN_HI  = 4'd1,
    ST_LEN_LO  = 4'd2,
    ST_DATA_HI = 4'd3,
    ST_DATA_LO = 4'd4,
    ST_WRITE   = 4'd5,
    ST_CHECK   = 4'd6,
    ST_DONE    = 4'd7,
    ST_ERROR   = 4'd8
  } state_t;

  localparam int LEN_BYTES = 2;
  localparam int LEN_WIDTH = 8 * LEN_BYTES;

  // Program words arrive high byte first.
  localparam bit WORD_BIG_ENDIAN = 1'b1;

  function automatic logic [15:0] place_byte(input logic [15:0] word,
                                             input logic [7:0]  data_byte,
                                             input logic        is_first);
    logic [15:0] result;
    result = word;
    if (is_first == WORD_BIG_ENDIAN) begin
      result[15:8] = data_byte;
    end else begin
      result[7:0] = data_byte;
    end
    return result;
  endfunction

  function automatic logic accepts_bytes(input state_t state);
    return (state == ST_LEN_HI)  || (state == ST_LEN_LO) ||
           (state == ST_DATA_HI) || (state == ST_DATA_LO) ||
           (state == ST_CHECK);
  endfunction

  function automatic logic can_start(input state_t state);
    return (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR);
  endfunction

endpackage

// File: rtl/program_loader_checksum.sv
// Running XOR over every accepted stream byte; cleared when a load is armed.
module program_loader_checksum (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clear,
  input  logic       i_enable,
  input  logic [7:0] i_byte,
  output logic [7:0] o_checksum
);

  logic [7:0] acc_q;
  logic [7:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (i_clear) begin
      acc_d = 8'h00;
    end else if (i_enable) begin
      acc_d = acc_q ^ i_byte;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      acc_q <= 8'h00;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign o_checksum = acc_q;

endmodule

// File: rtl/program_loader.sv
// Length-prefixed byte stream to program memory write master.
// Define PROGRAM_LOADER_CHECKSUM_EN to require an XOR trailer byte after the data.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 10,
  parameter int unsigned START_ADDRESS = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_byte_valid,
  input  logic [7:0]            i_byte,
  output logic                  o_byte_ready,
  output logic                  o_write,
  output logic [ADDR_WIDTH-1:0] o_write_address,
  output logic [15:0]           o_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [ADDR_WIDTH:0]   o_word_count
);

  // Words that fit between START_ADDRESS and the top of memory.
  localparam int unsigned CAPACITY = (32'd1 << ADDR_WIDTH) - START_ADDRESS;
  localparam logic [ADDR_WIDTH-1:0] START_ADDR = ADDR_WIDTH'(START_ADDRESS);

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           data_q, data_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  ready_q, ready_d;
  logic                  write_q, write_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic                  byte_accept;
  logic                  start_accept;
  logic [LEN_WIDTH-1:0]  len_full;
  logic                  len_bad;
  logic [ADDR_WIDTH:0]   count_inc;
  logic                  last_word;

  assign byte_accept  = i_byte_valid && ready_q;
  assign start_accept = i_start && can_start(state_q);
  assign len_full     = {len_q[LEN_WIDTH-1:8], i_byte};
  assign len_bad      = (len_full == '0) || (32'(len_full) > CAPACITY);
  assign count_inc    = count_q + (ADDR_WIDTH+1)'(1);
  assign last_word    = (32'(count_inc) == 32'(len_q));

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0] checksum;

  program_loader_checksum u_checksum (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    (start_accept),
    .i_enable   (byte_accept),
    .i_byte     (i_byte),
    .o_checksum (checksum)
  );
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    addr_d  = addr_q;
    data_d  = data_q;
    count_d = count_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start_accept) begin
          state_d = ST_LEN_HI;
          count_d = '0;
          addr_d  = START_ADDR;
        end
      end
      ST_LEN_HI: begin
        if (byte_accept) begin
          len_d[LEN_WIDTH-1:8] = i_byte;
          state_d              = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (byte_accept) begin
          len_d   = len_full;
          state_d = len_bad ? ST_ERROR : ST_DATA_HI;
        end
      end
      ST_DATA_HI: begin
        if (byte_accept) begin
          data_d  = place_byte(data_q, i_byte, 1'b1);
          state_d = ST_DATA_LO;
        end
      end
      ST_DATA_LO: begin
        if (byte_accept) begin
          data_d  = place_byte(data_q, i_byte, 1'b0);
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // The length check already bounded the final address, so no wrap guard.
        addr_d  = addr_q + ADDR_WIDTH'(1);
        count_d = count_inc;
        if (last_word) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          state_d = ST_CHECK;
`else
          state_d = ST_DONE;
`endif
        end else begin
          state_d = ST_DATA_HI;
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (byte_accept) begin
          state_d = (i_byte == checksum) ? ST_DONE : ST_ERROR;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // Status flags are decoded from the next state so every output is a flop.
    ready_d = accepts_bytes(state_d);
    write_d = (state_d == ST_WRITE);
    busy_d  = ready_d || write_d;
    done_d  = (state_d == ST_DONE);
    error_d = (state_d == ST_ERROR);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      addr_q  <= START_ADDR;
      data_q  <= '0;
      count_q <= '0;
      ready_q <= 1'b0;
      write_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      count_q <= count_d;
      ready_q <= ready_d;
      write_q <= write_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign o_byte_ready    = ready_q;
  assign o_write         = write_q;
  assign o_write_address = addr_q;
  assign o_data          = data_q;
  assign o_busy          = busy_q;
  assign o_done          = done_q;
  assign o_error         = error_q;
  assign o_word_count    = count_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomised scoreboard bench for program_loader: a stream-level model predicts
// the memory writes and final status; a monitor checks every write pulse.
module tb_program_loader;

  localparam int AW  = 10;
  localparam int CAP = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          write;
  logic [AW-1:0] waddr;
  logic [15:0]   wdata;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW:0]   wcount;

  always #5 clk = ~clk;

  program_loader #(.ADDR_WIDTH(AW), .START_ADDRESS(0)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_start         (start),
    .i_byte_valid    (byte_valid),
    .i_byte          (byte_data),
    .o_byte_ready    (byte_ready),
    .o_write         (write),
    .o_write_address (waddr),
    .o_data          (wdata),
    .o_busy          (busy),
    .o_done          (done),
    .o_error         (error),
    .o_word_count    (wcount)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  bit  exp_done;
  bit  exp_error;
  int  exp_count;
  int  exp_consumed;
  int  accepted;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] xor_prefix(input logic [7:0] s[$], input int len);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < len; i++) x = x ^ s[i];
    return x;
  endfunction

  // Expected behaviour straight from the stream format: header, N word pairs, optional trailer.
  task automatic model(input logic [7:0] s[$]);
    int n;
    n = int'({s[0], s[1]});
    exp_done  = 1'b0;
    exp_error = 1'b0;
    exp_count = 0;
    if (n == 0 || n > CAP) begin
      exp_error    = 1'b1;
      exp_consumed = 2;
      return;
    end
    for (int i = 0; i < n; i++) begin
      wr_t w;
      w.addr = AW'(i);
      w.data = {s[2 + 2*i], s[3 + 2*i]};
      exp_q.push_back(w);
    end
    exp_count    = n;
    exp_consumed = 2 + 2*n;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    exp_consumed++;
    if (s.size() > 2 + 2*n && s[2 + 2*n] == xor_prefix(s, 2 + 2*n)) exp_done = 1'b1;
    else exp_error = 1'b1;
`else
    exp_done = 1'b1;
`endif
  endtask

  task automatic build(input int n, output logic [7:0] s[$]);
    s = {};
    s.push_back(n[15:8]);
    s.push_back(n[7:0]);
    for (int i = 0; i < 2*n; i++) s.push_back(8'($urandom_range(0, 255)));
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    s.push_back(xor_prefix(s, s.size()));
`endif
  endtask

  task automatic run_load(input string name, input logic [7:0] s[$], input bit poke_start);
    int idx;
    int cyc;
    bit fin;
    idx = 0;
    cyc = 0;
    fin = 1'b0;
    accepted = 0;
    model(s);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!fin && cyc < 20000) begin
      if (!busy) begin
        fin = 1'b1;
      end else begin
        byte_valid = (idx < s.size()) && ($urandom_range(0, 3) != 0);
        byte_data  = (idx < s.size()) ? s[idx] : 8'h00;
        start      = poke_start && ($urandom_range(0, 15) == 0);
        if (byte_valid && byte_ready) begin
          idx++;
          accepted++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    byte_valid = 1'b0;
    start      = 1'b0;
    check({name, "_finished"}, 32'(fin), 32'd1);
    // Sampled on the first cycle busy is low, so done/error must rise together with it.
    check({name, "_done"}, 32'(done), 32'(exp_done));
    check({name, "_error"}, 32'(error), 32'(exp_error));
    check({name, "_word_count"}, 32'(wcount), 32'(exp_count));
    check({name, "_bytes_consumed"}, 32'(accepted), 32'(exp_consumed));
    check({name, "_writes_missing"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    $display("load %s: words=%0d done=%0b error=%0b bytes=%0d cycles=%0d",
             name, wcount, done, error, accepted, cyc);
  endtask

  always @(negedge clk) begin
    wr_t w;
    if (rst_n === 1'b1 && write === 1'b1) begin
      check("write_ready_overlap", 32'(byte_ready), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", 32'(waddr), 32'hFFFF_FFFF);
      end else begin
        w = exp_q.pop_front();
        check("write_addr", 32'(waddr), 32'(w.addr));
        check("write_data", 32'(wdata), 32'(w.data));
      end
    end
  end

  task automatic reset_mid_load();
    logic [7:0] s[$];
    wr_t w;
    int  idx;
    bit  seen;
    build(3, s);
    w.addr = '0;
    w.data = {s[2], s[3]};
    exp_q.push_back(w);
    idx  = 0;
    seen = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      if (write) begin
        seen = 1'b1;
      end else begin
        byte_valid = 1'b1;
        byte_data  = s[idx];
        if (byte_ready) idx++;
        @(negedge clk);
      end
    end
    check("rst_first_write_seen", 32'(seen), 32'd1);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(byte_ready), 32'd0);
    check("rst_write", 32'(write), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_addr", 32'(waddr), 32'd0);
    check("rst_data", 32'(wdata), 32'd0);
    check("rst_count", 32'(wcount), 32'd0);
    rst_n    = 1'b1;
    accepted = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (byte_valid && byte_ready) accepted++;
    end
    byte_valid = 1'b0;
    check("rst_bytes_ignored", 32'(accepted), 32'd0);
    check("rst_stays_idle", 32'(busy), 32'd0);
    check("rst_first_word_popped", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    $display("load reset_mid_load: first word written, then reset; later bytes ignored");
  endtask

  initial begin
    logic [7:0] s[$];
    rst_n      = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(byte_ready), 32'd0);
    check("reset_write", 32'(write), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_error", 32'(error), 32'd0);
    check("reset_addr", 32'(waddr), 32'd0);
    check("reset_data", 32'(wdata), 32'd0);
    check("reset_count", 32'(wcount), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    s.push_back(xor_prefix(s, s.size()));
`endif
    run_load("basic", s, 1'b0);

    s = '{8'h00, 8'h00};
    run_load("zero_length", s, 1'b0);

    s = '{8'h04, 8'h01};
    run_load("oversize", s, 1'b0);

    build(CAP, s);
    run_load("full_capacity", s, 1'b0);

    for (int k = 0; k < 8; k++) begin
      build($urandom_range(1, 24), s);
      run_load("random_backpressure", s, 1'b1);
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    s = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h27};
    run_load("checksum_good", s, 1'b0);
    s = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h00};
    run_load("checksum_bad", s, 1'b0);
`else
    s = '{8'h00, 8'h01, 8'h12, 8'h34};
    run_load("single_word", s, 1'b0);
`endif

    reset_mid_load();

    build(5, s);
    run_load("after_reset", s, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Write-side master for the 1024×16 program memory. It receives a length-prefixed byte stream, typically from the UART receiver, assembles big-endian 16-bit words and drives the memory's synchronous write port with consecutive addresses. It asserts a busy flag so the core is held off while a program is loading, and it reports completion or error to the control logic.

## Interface
- ADDR_WIDTH, 10: program memory address width; capacity is 2^ADDR_WIDTH words.
- START_ADDRESS, 0: first address written for each load.
- i_clk  in  1  system clock; all activity on the rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_start  in  1  single-cycle pulse that arms a load; honoured only in IDLE, DONE or ERROR.
- i_byte_valid  in  1  byte stream valid.
- i_byte  in  8  byte stream data.
- o_byte_ready  out  1  byte stream ready; a byte is accepted on any edge where valid and ready are both high.
- o_write  out  1  program memory write strobe, one cycle per word.
- o_write_address  out  ADDR_WIDTH  program memory write address.
- o_data  out  16  program memory write data.
- o_busy  out  1  high from the start of a load until DONE or ERROR.
- o_done  out  1  load finished cleanly; sticky until the next i_start.
- o_error  out  1  bad length or checksum; sticky until the next i_start.
- o_word_count  out  ADDR_WIDTH+1  number of words written during the current load.

## Operation
- FSM states: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHECK (macro only), DONE, ERROR.
- **IDLE/DONE/ERROR**
  - i_start moves the FSM to LEN_HI.
  - It also clears o_done, o_error and o_word_count, and loads the address counter with START_ADDRESS.
- **Length header**
  - LEN_HI then LEN_LO each accept one byte and form the 16-bit word count N, high byte first.
  - In LEN_LO, N = 0 or N > 2^ADDR_WIDTH − START_ADDRESS goes to ERROR; otherwise the FSM goes to DATA_HI.
- **Data**
  - DATA_HI accepts the high byte, then DATA_LO accepts the low byte, then WRITE.
  - WRITE lasts one cycle: o_write=1 with the registered address and data.
  - On the WRITE edge the address increments and o_word_count increments.
  - If the count now equals N, the FSM goes to CHECK, or to DONE without the macro; else it returns to DATA_HI.
- o_byte_ready is 1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHECK.
- i_start while busy is ignored.
- Bytes offered while ready=0 are not consumed; the source holds them.
- The address never wraps: the length check guarantees the last address is ≤ 2^ADDR_WIDTH−1.
- Reset mid-load: the FSM returns to IDLE and all outputs go to their reset values. No further writes occur, and words already written remain in memory.

## Timing
- Reset values:
  - o_byte_ready, o_write, o_busy, o_done, o_error = 0.
  - o_write_address = START_ADDRESS.
  - o_data = 0.
  - o_word_count = 0.
- All outputs are registered.
- o_write is high in the cycle after the low byte is accepted; the memory captures the word on the edge that ends that cycle.
- Minimum 3 cycles per word with continuous valid bytes; header adds 2 cycles.
- o_busy rises the cycle after i_start. It falls in the same cycle that o_done or o_error rises.

## Configuration
- PROGRAM_LOADER_CHECKSUM_EN defined:
  - An XOR accumulator covers every accepted byte, length bytes included.
  - After the last WRITE, CHECK accepts one trailer byte.
  - If the trailer equals the accumulator → DONE, else → ERROR. Words already written are not rolled back.
- Undefined:
  - No CHECK state and no trailer byte.
  - The last WRITE goes directly to DONE.

## Structure
- Shared package program_loader_pkg holds:
  - the state encodings;
  - LEN_BYTES=2 and the word byte order constant.
- One sub-module, program_loader_checksum, holds the XOR accumulator with clear and enable. It is instantiated only under PROGRAM_LOADER_CHECKSUM_EN.

## Test plan
- **Basic load:** i_start, then stream 00 02 12 34 AB CD → writes 0x1234@0x000 and 0xABCD@0x001, o_word_count=2, o_done=1.
- **Zero length:** stream 00 00 → o_error=1, no o_write pulses, o_busy=0.
- **Oversize length:** stream 04 01 (1025) → o_error=1. Then full 1024-word load → last write at 0x3FF, done, no wrap.
- **Backpressure:** valid toggled randomly; assert each byte is consumed exactly once and o_write never coincides with o_byte_ready.
- **Reset mid-load:** i_rst_n=0 after 1 of 3 words → all outputs at reset values next cycle; later bytes ignored until i_start.
- **Checksum (macro on):** 00 01 12 34 then trailer 27 → done. Trailer 00 → error with 0x1234 still written at 0x000.
